alu_seq_ctrl: RTL and testbench

- Sequencing stage directly upstream of the 8-bit combinational ALU (4-bit op, flags C/Z/S/P).
- Accepts operation requests over a valid/ready handshake, registers the ALU operands and op, and owns the architectural flag register that feeds Cin/Zin/Sin/Pin.
- Captures ALU result and flags, and returns the result downstream over valid/ready.
- For shift/rotate ops (op[3]=1), iterates the ALU multiple passes to implement multi-bit shifts.

---
 rtl/alu_seq_ctrl.sv | 96 +++++++++
 tb/tb_alu_seq_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// Sequencer in front of the combinational ALU: registers operands/op, owns the
// {C,Z,S,P} flag register, repeats shift/rotate passes and returns the result.
module alu_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [CNT_W-1:0] req_cnt,
    input  logic             flag_clr,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    output logic             alu_cin,
    output logic             alu_zin,
    output logic             alu_sin,
    output logic             alu_pin,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_c,
    input  logic             alu_z,
    input  logic             alu_s,
    input  logic             alu_p,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [3:0]       flags
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state, stateNext;
    logic [CNT_W-1:0] passCnt;
    logic [3:0]       flagReg;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (req_valid) stateNext = EXEC;
            EXEC:    if (passCnt == '0) stateNext = RESP;
            RESP:    if (rsp_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Datapath registers; each pass feeds the ALU result back into operand A.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            flagReg   <= '0;
            rsp_data  <= '0;
            rsp_valid <= 1'b0;
            passCnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (flag_clr) flagReg <= '0;
                    if (req_valid) begin
                        alu_op  <= req_op;
                        alu_a   <= req_a;
                        alu_b   <= req_b;
                        passCnt <= req_op[3] ? req_cnt : '0;
                    end
                end
                EXEC: begin
                    flagReg <= {alu_c, alu_z, alu_s, alu_p};
                    if (passCnt != '0) begin
                        alu_a   <= alu_out;
                        passCnt <= passCnt - CNT_W'(1);
                    end else begin
                        rsp_data  <= alu_out;
                        rsp_valid <= 1'b1;
                    end
                end
                RESP: if (rsp_ready) rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign req_ready = (state == IDLE);
    assign {alu_cin, alu_zin, alu_sin, alu_pin} = flagReg;
    assign flags = flagReg;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: a behavioural 8-bit ALU closes the loop, and a
// scoreboard queue holds expected {data, flags, passes} per request.
module tb_alu_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0, req_ready;
    logic [3:0] req_op = '0;
    logic [7:0] req_a = '0, req_b = '0;
    logic [2:0] req_cnt = '0;
    logic       flag_clr = 1'b0;
    logic [7:0] alu_a, alu_b, alu_out;
    logic [3:0] alu_op;
    logic       alu_cin, alu_zin, alu_sin, alu_pin;
    logic       alu_c, alu_z, alu_s, alu_p;
    logic       rsp_valid, rsp_ready = 1'b1;
    logic [7:0] rsp_data;
    logic [3:0] flags;

    int cmpCnt = 0;
    int errCnt = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0] data;
        logic [3:0] flags;
        int         passes;
    } exp_t;
    exp_t       sbq[$];
    logic [3:0] mf = '0;  // model flag register {C,Z,S,P}

    alu_seq_ctrl #(.WIDTH(8), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_cnt(req_cnt), .flag_clr(flag_clr),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_cin(alu_cin), .alu_zin(alu_zin), .alu_sin(alu_sin), .alu_pin(alu_pin),
        .alu_out(alu_out), .alu_c(alu_c), .alu_z(alu_z), .alu_s(alu_s), .alu_p(alu_p),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .flags(flags)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Returns {C,Z,S,P,result}; P is the XOR of the result bits.
    function automatic logic [11:0] aluModel(input logic [3:0] op, input logic [7:0] a,
                                             input logic [7:0] b, input logic cin);
        logic [8:0] w;
        logic [7:0] r;
        logic       c;
        w = '0; r = '0; c = 1'b0;
        case (op)
            4'h0: begin w = {1'b0, a} + {1'b0, b};               r = w[7:0]; c = w[8]; end
            4'h1: begin w = {1'b0, a} + {1'b0, b} + {8'b0, cin}; r = w[7:0]; c = w[8]; end
            4'h2: begin w = {1'b0, a} - {1'b0, b};               r = w[7:0]; c = w[8]; end
            4'h3: begin w = {1'b0, a} - {1'b0, b} - {8'b0, cin}; r = w[7:0]; c = w[8]; end
            4'h4: r = a;
            4'h5: r = a & b;
            4'h6: r = a | b;
            4'h7: r = a ^ b;
            4'h8: begin r = {1'b0, a[7:1]}; c = a[0]; end
            4'h9: begin r = {a[7], a[7:1]}; c = a[0]; end
            4'hA, 4'hB: begin r = {a[6:0], 1'b0}; c = a[7]; end
            4'hC: begin r = {a[6:0], a[7]}; c = a[7]; end
            4'hD: begin r = {a[0], a[7:1]}; c = a[0]; end
            4'hE: begin r = {a[6:0], cin}; c = a[7]; end
            default: begin r = {cin, a[7:1]}; c = a[0]; end
        endcase
        return {c, (r == 8'h00), r[7], ^r, r};
    endfunction

    logic [11:0] aluRes;
    assign aluRes = aluModel(alu_op, alu_a, alu_b, alu_cin);
    assign {alu_c, alu_z, alu_s, alu_p, alu_out} = aluRes;

    task automatic push_exp(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                            input logic [2:0] cnt, input logic clr);
        exp_t        e;
        logic [11:0] r;
        logic [7:0]  x;
        int          n;
        if (clr) mf = '0;
        n = op[3] ? int'(cnt) : 0;
        x = a;
        for (int i = 0; i <= n; i++) begin
            r  = aluModel(op, x, b, mf[3]);
            mf = r[11:8];
            x  = r[7:0];
        end
        e.data = x; e.flags = mf; e.passes = n + 1;
        sbq.push_back(e);
    endtask

    // Issues one request from IDLE and waits (bounded) for its response.
    task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] cnt, input logic clr,
                        output logic [7:0] d, output logic [3:0] f,
                        output int passes, output int acc, output bit tmo);
        push_exp(op, a, b, cnt, clr);
        req_op = op; req_a = a; req_b = b; req_cnt = cnt; flag_clr = clr; req_valid = 1'b1;
        @(posedge clk); #1;
        acc = cyc;
        req_valid = 1'b0; flag_clr = 1'b0;
        passes = 0; tmo = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid) begin tmo = 1'b0; break; end
            passes++;
        end
        d = rsp_data; f = flags;
        if (rsp_ready) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b1; req_op = 4'hA; req_a = 8'h5A; req_b = 8'h33; req_cnt = 3'd3;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        cmpCnt++; if (req_ready !== 1'b1) begin errCnt++; $display("FAIL reset.req_ready got %b want 1", req_ready); end
        cmpCnt++; if (rsp_valid !== 1'b0) begin errCnt++; $display("FAIL reset.rsp_valid got %b want 0", rsp_valid); end
        cmpCnt++; if (flags !== 4'h0) begin errCnt++; $display("FAIL reset.flags got %b want 0000", flags); end
        cmpCnt++; if (alu_op !== 4'h0) begin errCnt++; $display("FAIL reset.alu_op got %h want 0", alu_op); end
        cmpCnt++; if (alu_a !== 8'h00) begin errCnt++; $display("FAIL reset.alu_a got %h want 00", alu_a); end
        cmpCnt++; if (rsp_data !== 8'h00) begin errCnt++; $display("FAIL reset.rsp_data got %h want 00", rsp_data); end
        mf = '0;
    endtask

    task automatic test_add();
        logic [7:0] d; logic [3:0] f; int p, acc; bit tmo; exp_t e;
        send(4'h0, 8'h7F, 8'h01, 3'd5, 1'b0, d, f, p, acc, tmo);
        e = sbq.pop_front();
        cmpCnt++; if (tmo) begin errCnt++; $display("FAIL add.timeout got 1 want 0"); end
        cmpCnt++; if (d !== e.data) begin errCnt++; $display("FAIL add.data got %h want %h", d, e.data); end
        cmpCnt++; if (d !== 8'h80) begin errCnt++; $display("FAIL add.data_const got %h want 80", d); end
        cmpCnt++; if (f !== e.flags) begin errCnt++; $display("FAIL add.flags got %b want %b", f, e.flags); end
        cmpCnt++; if ({f[3], f[2], f[0]} !== 3'b001) begin errCnt++; $display("FAIL add.CZP got %b want 001", {f[3], f[2], f[0]}); end
        cmpCnt++; if (p !== 1) begin errCnt++; $display("FAIL add.passes got %0d want 1", p); end
    endtask

    task automatic test_carry_chain();
        logic [3:0] ops[3]  = '{4'h0, 4'h1, 4'h1};
        logic [7:0] as[3]   = '{8'hFF, 8'h00, 8'h00};
        logic [7:0] bs[3]   = '{8'h01, 8'h00, 8'h00};
        logic       clrs[3] = '{1'b0, 1'b0, 1'b1};
        logic [7:0] want[3] = '{8'h00, 8'h01, 8'h00};
        logic       wc[3]   = '{1'b1, 1'b0, 1'b0};
        logic [7:0] d; logic [3:0] f; int p, acc; bit tmo; exp_t e;
        for (int i = 0; i < 3; i++) begin
            send(ops[i], as[i], bs[i], 3'd0, clrs[i], d, f, p, acc, tmo);
            e = sbq.pop_front();
            cmpCnt++; if (tmo) begin errCnt++; $display("FAIL chain%0d.timeout got 1 want 0", i); end
            cmpCnt++; if (d !== e.data) begin errCnt++; $display("FAIL chain%0d.data got %h want %h", i, d, e.data); end
            cmpCnt++; if (d !== want[i]) begin errCnt++; $display("FAIL chain%0d.data_const got %h want %h", i, d, want[i]); end
            cmpCnt++; if (f !== e.flags) begin errCnt++; $display("FAIL chain%0d.flags got %b want %b", i, f, e.flags); end
            cmpCnt++; if (f[3] !== wc[i]) begin errCnt++; $display("FAIL chain%0d.C got %b want %b", i, f[3], wc[i]); end
        end
    endtask

    task automatic test_shift();
        logic [3:0] ops[3]  = '{4'hA, 4'h5, 4'hC};
        logic [7:0] as[3]   = '{8'h01, 8'h3C, 8'h81};
        logic [7:0] bs[3]   = '{8'h00, 8'h0F, 8'h00};
        logic [2:0] cnts[3] = '{3'd3, 3'd7, 3'd7};
        logic [7:0] want[3] = '{8'h10, 8'h0C, 8'h81};
        int         wp[3]   = '{4, 1, 8};
        logic [7:0] d; logic [3:0] f; int p, acc; bit tmo; exp_t e;
        for (int i = 0; i < 3; i++) begin
            send(ops[i], as[i], bs[i], cnts[i], 1'b0, d, f, p, acc, tmo);
            e = sbq.pop_front();
            cmpCnt++; if (tmo) begin errCnt++; $display("FAIL shift%0d.timeout got 1 want 0", i); end
            cmpCnt++; if (d !== e.data) begin errCnt++; $display("FAIL shift%0d.data got %h want %h", i, d, e.data); end
            cmpCnt++; if (d !== want[i]) begin errCnt++; $display("FAIL shift%0d.data_const got %h want %h", i, d, want[i]); end
            cmpCnt++; if (f !== e.flags) begin errCnt++; $display("FAIL shift%0d.flags got %b want %b", i, f, e.flags); end
            cmpCnt++; if (p !== wp[i]) begin errCnt++; $display("FAIL shift%0d.passes got %0d want %0d", i, p, wp[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops[3]  = '{4'h0, 4'hA, 4'h7};
        logic [7:0] as[3]   = '{8'h10, 8'h03, 8'hA5};
        logic [7:0] bs[3]   = '{8'h20, 8'h00, 8'h5A};
        logic [2:0] cnts[3] = '{3'd0, 3'd2, 3'd0};
        logic [7:0] d[3]; logic [3:0] f[3]; int p[3], acc[3]; bit tmo[3]; exp_t e;
        for (int i = 0; i < 3; i++)
            send(ops[i], as[i], bs[i], cnts[i], 1'b0, d[i], f[i], p[i], acc[i], tmo[i]);
        for (int i = 0; i < 3; i++) begin
            e = sbq.pop_front();
            cmpCnt++; if (tmo[i]) begin errCnt++; $display("FAIL b2b%0d.timeout got 1 want 0", i); end
            cmpCnt++; if (d[i] !== e.data) begin errCnt++; $display("FAIL b2b%0d.data got %h want %h", i, d[i], e.data); end
            cmpCnt++; if (f[i] !== e.flags) begin errCnt++; $display("FAIL b2b%0d.flags got %b want %b", i, f[i], e.flags); end
        end
        cmpCnt++; if (acc[1] - acc[0] !== 3) begin errCnt++; $display("FAIL b2b.spacing0 got %0d want 3", acc[1] - acc[0]); end
        cmpCnt++; if (acc[2] - acc[1] !== 5) begin errCnt++; $display("FAIL b2b.spacing1 got %0d want 5", acc[2] - acc[1]); end
    endtask

    task automatic test_backpressure();
        logic [7:0] d0, d; logic [3:0] f0; bit tmo; exp_t e;
        rsp_ready = 1'b0;
        push_exp(4'h2, 8'h10, 8'h20, 3'd0, 1'b0);
        req_op = 4'h2; req_a = 8'h10; req_b = 8'h20; req_cnt = 3'd0; req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        tmo = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin tmo = 1'b0; break; end
        end
        d0 = rsp_data; f0 = flags;
        e = sbq.pop_front();
        cmpCnt++; if (tmo) begin errCnt++; $display("FAIL bp.timeout got 1 want 0"); end
        cmpCnt++; if (d0 !== e.data) begin errCnt++; $display("FAIL bp.data got %h want %h", d0, e.data); end
        cmpCnt++; if (f0 !== e.flags) begin errCnt++; $display("FAIL bp.flags got %b want %b", f0, e.flags); end
        // A new request waits while the response is stalled.
        push_exp(4'h7, 8'hFF, 8'h0F, 3'd0, 1'b0);
        req_op = 4'h7; req_a = 8'hFF; req_b = 8'h0F; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cmpCnt++; if (rsp_valid !== 1'b1) begin errCnt++; $display("FAIL bp.hold%0d.rsp_valid got %b want 1", i, rsp_valid); end
            cmpCnt++; if (req_ready !== 1'b0) begin errCnt++; $display("FAIL bp.hold%0d.req_ready got %b want 0", i, req_ready); end
            cmpCnt++; if (rsp_data !== d0) begin errCnt++; $display("FAIL bp.hold%0d.data got %h want %h", i, rsp_data, d0); end
            cmpCnt++; if (flags !== f0) begin errCnt++; $display("FAIL bp.hold%0d.flags got %b want %b", i, flags, f0); end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        cmpCnt++; if (rsp_valid !== 1'b0) begin errCnt++; $display("FAIL bp.release.rsp_valid got %b want 0", rsp_valid); end
        cmpCnt++; if (req_ready !== 1'b1) begin errCnt++; $display("FAIL bp.release.req_ready got %b want 1", req_ready); end
        cmpCnt++; if (alu_op !== 4'h2) begin errCnt++; $display("FAIL bp.release.alu_op got %h want 2", alu_op); end
        @(posedge clk); #1 req_valid = 1'b0;
        tmo = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin tmo = 1'b0; break; end
        end
        d = rsp_data;
        e = sbq.pop_front();
        cmpCnt++; if (tmo) begin errCnt++; $display("FAIL bp.next.timeout got 1 want 0"); end
        cmpCnt++; if (d !== e.data) begin errCnt++; $display("FAIL bp.next.data got %h want %h", d, e.data); end
        cmpCnt++; if (flags !== e.flags) begin errCnt++; $display("FAIL bp.next.flags got %b want %b", flags, e.flags); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [7:0] d; logic [3:0] f; int p, acc, seen; bit tmo; exp_t e;
        req_op = 4'hC; req_a = 8'h81; req_b = 8'h00; req_cnt = 3'd7; req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        mf = '0;
        @(negedge clk);
        cmpCnt++; if (req_ready !== 1'b1) begin errCnt++; $display("FAIL rstmid.req_ready got %b want 1", req_ready); end
        cmpCnt++; if (rsp_valid !== 1'b0) begin errCnt++; $display("FAIL rstmid.rsp_valid got %b want 0", rsp_valid); end
        cmpCnt++; if (flags !== 4'h0) begin errCnt++; $display("FAIL rstmid.flags got %b want 0000", flags); end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        cmpCnt++; if (seen !== 0) begin errCnt++; $display("FAIL rstmid.rsp_seen got %0d want 0", seen); end
        send(4'h1, 8'h01, 8'h01, 3'd0, 1'b0, d, f, p, acc, tmo);
        e = sbq.pop_front();
        cmpCnt++; if (tmo) begin errCnt++; $display("FAIL rstmid.after.timeout got 1 want 0"); end
        cmpCnt++; if (d !== 8'h02) begin errCnt++; $display("FAIL rstmid.after.data got %h want 02", d); end
        cmpCnt++; if (f !== e.flags) begin errCnt++; $display("FAIL rstmid.after.flags got %b want %b", f, e.flags); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_carry_chain();
        test_shift();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        cmpCnt++; if (sbq.size() != 0) begin errCnt++; $display("FAIL sb.leftover got %0d want 0", sbq.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
